// File: rtl/priority_arbiter_n_pkg.sv
// Shared constants and helpers for the registered N-way priority arbiter.
package priority_arbiter_n_pkg;

    // Arbitration mode selectors for the RR_MODE parameter.
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ceiling log2 for toolflows that do not provide $clog2. A value of 1
    // still needs one bit, so the result is never below 1.
    function automatic int clog2_f(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/priority_arbiter_n_scan.sv
// Combinational highest-set-bit finder: reports whether any bit of req is
// set and, if so, the index of the highest one.
module prio_scan_n #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] index
);

    // Ascending scan, so the last set bit seen (the highest) overwrites
    // earlier ones.
    always_comb begin
        found = |req;
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_n.sv
// Registered N-way arbiter with a valid/ready output stage. Fixed mode
// grants the highest requesting index; round-robin mode scans downward from
// a rotating pointer so every requester is served once per N grants.
module priority_arbiter_n
    import priority_arbiter_n_pkg::*;
#(
    parameter int N       = 8,
    parameter int W       = $clog2(N),
    parameter int RR_MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant
);

    // Highest legal index; the round-robin pointer wraps here rather than to
    // 2^W-1 so non-power-of-two N never produces an out-of-range index.
    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic         valid_reg;
    logic [W-1:0] idx_reg;
    logic [N-1:0] grant_reg;

    logic         load;
    logic         full_found;
    logic [W-1:0] full_idx;
    logic         win_found;
    logic [W-1:0] win_idx;
    logic [N-1:0] grant_next;

    // The output register may take a new result whenever it is empty or the
    // consumer is taking the current one. Requests are not buffered while
    // stalled; they are simply re-sampled once the stall clears.
    assign load = !valid_reg || out_ready;

    // Unmasked scan: the fixed-priority winner, and the round-robin fallback
    // when nothing at or below the pointer is requesting.
    prio_scan_n #(
        .N (N),
        .W (W)
    ) u_scan_full (
        .req   (req),
        .found (full_found),
        .index (full_idx)
    );

    generate
        if (RR_MODE == MODE_RR) begin : g_rr
            logic [W-1:0] ptr_reg;
            logic [W-1:0] ptr_next;
            logic [N-1:0] mask;
            logic [N-1:0] req_masked;
            logic         masked_found;
            logic [W-1:0] masked_idx;

            // Keep only requesters at or below the pointer; the highest of
            // these is the first hit of the scan ptr, ptr-1, ..., 0.
            for (genvar gi = 0; gi < N; gi++) begin : g_mask
                localparam logic [W:0] POS = (W + 1)'(gi);
                assign mask[gi] = ({1'b0, ptr_reg} >= POS);
            end

            assign req_masked = req & mask;

            prio_scan_n #(
                .N (N),
                .W (W)
            ) u_scan_masked (
                .req   (req_masked),
                .found (masked_found),
                .index (masked_idx)
            );

            // Nothing at or below ptr means the scan wraps to N-1 and
            // continues down to ptr+1, which is the plain highest set bit.
            assign win_found = full_found;
            assign win_idx   = masked_found ? masked_idx : full_idx;

            // Move the pointer just below the latest winner so that winner
            // becomes lowest priority; winner 0 wraps to the top index.
            always_comb begin
                ptr_next = ptr_reg;
                if (load && full_found) begin
                    if (win_idx == '0) begin
                        ptr_next = LAST_IDX;
                    end else begin
                        ptr_next = win_idx - W'(1);
                    end
                end
            end

            // Pointer register; reset to N-1 so the first round-robin
            // decision matches fixed priority.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_reg <= LAST_IDX;
                end else begin
                    ptr_reg <= ptr_next;
                end
            end
        end else begin : g_fixed
            assign win_found = full_found;
            assign win_idx   = full_idx;
        end
    endgenerate

    // One-hot decode of the winner; all zeros when nobody is requesting.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            localparam logic [W-1:0] POS = W'(gi);
            assign grant_next[gi] = win_found && (win_idx == POS);
        end
    endgenerate

    // Output stage: capture a new result on load, freeze it on a stall.
    // With no requests the result goes invalid but idx keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            grant_reg <= '0;
        end else if (load) begin
            valid_reg <= win_found;
            grant_reg <= grant_next;
            if (win_found) begin
                idx_reg <= win_idx;
            end
        end
    end

    assign out_valid = valid_reg;
    assign idx       = idx_reg;
    assign grant     = grant_reg;

    // Structural invariants of the output register.
    a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_reg));
    a_grant_zero_when_idle : assert property (@(posedge clk) disable iff (rst)
        !valid_reg |-> (grant_reg == '0));
    a_idx_in_range : assert property (@(posedge clk) disable iff (rst)
        idx_reg <= LAST_IDX);

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Self-checking bench for priority_arbiter_n: a fixed-priority N=4 instance,
// a round-robin N=8 instance and a round-robin N=5 instance share one clock
// and reset. Expectations are queued when stimulus is driven and popped when
// the registered result appears one cycle later.
module tb_priority_arbiter_n;
    import priority_arbiter_n_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [3:0] req4;
    logic       rdy4;
    logic       v4;
    logic [1:0] idx4;
    logic [3:0] g4;

    logic [7:0] req8;
    logic       rdy8;
    logic       v8;
    logic [2:0] idx8;
    logic [7:0] g8;

    logic [4:0] req5;
    logic       rdy5;
    logic       v5;
    logic [2:0] idx5;
    logic [4:0] g5;

    priority_arbiter_n #(.N(4), .RR_MODE(MODE_FIXED)) u_fix4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req4),
        .out_ready (rdy4),
        .out_valid (v4),
        .idx       (idx4),
        .grant     (g4)
    );

    priority_arbiter_n #(.N(8), .RR_MODE(MODE_RR)) u_rr8 (
        .clk       (clk),
        .rst       (rst),
        .req       (req8),
        .out_ready (rdy8),
        .out_valid (v8),
        .idx       (idx8),
        .grant     (g8)
    );

    priority_arbiter_n #(.N(5), .RR_MODE(MODE_RR)) u_rr5 (
        .clk       (clk),
        .rst       (rst),
        .req       (req5),
        .out_ready (rdy5),
        .out_valid (v5),
        .idx       (idx5),
        .grant     (g5)
    );

    typedef struct {
        int         sel;
        logic       v;
        logic [2:0] idx;
        logic [7:0] grant;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       v;
        logic [2:0] idx;
        logic [7:0] grant;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    // Drive one transaction on the selected DUT, queue its expectation,
    // then compare the registered result after the next rising edge.
    task automatic step(input int sel, input logic [7:0] r, input logic rdy,
                        input logic v, input logic [2:0] ix, input logic [7:0] g,
                        input string tag, output logic [7:0] got_g);
        exp_t       e;
        logic       av;
        logic [2:0] ai;
        logic [7:0] ag;
        case (sel)
            4:       begin req4 = r[3:0]; rdy4 = rdy; end
            5:       begin req5 = r[4:0]; rdy5 = rdy; end
            default: begin req8 = r;      rdy8 = rdy; end
        endcase
        e.sel = sel; e.v = v; e.idx = ix; e.grant = g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        case (e.sel)
            4:       begin av = v4; ai = {1'b0, idx4}; ag = {4'b0, g4}; end
            5:       begin av = v5; ai = idx5;         ag = {3'b0, g5}; end
            default: begin av = v8; ai = idx8;         ag = g8;         end
        endcase
        $display("[%0t] %s N=%0d req=%0h rdy=%0b -> valid=%0b idx=%0d grant=%0h",
                 $time, tag, e.sel, r, rdy, av, ai, ag);
        check({tag, ".valid"}, {7'b0, av}, {7'b0, e.v});
        check({tag, ".idx"},   {5'b0, ai}, {5'b0, e.idx});
        check({tag, ".grant"}, ag, e.grant);
        got_g = ag;
    endtask

    // Apply reset and confirm every instance comes out empty with idx=0.
    task automatic do_reset(input string tag);
        rst  = 1'b1;
        req4 = '0; req8 = '0; req5 = '0;
        rdy4 = 1'b1; rdy8 = 1'b1; rdy5 = 1'b1;
        @(posedge clk);
        #1;
        $display("[%0t] %s reset -> v4=%0b v8=%0b v5=%0b", $time, tag, v4, v8, v5);
        check({tag, ".v4"},   {7'b0, v4},   8'h00);
        check({tag, ".idx4"}, {6'b0, idx4}, 8'h00);
        check({tag, ".g4"},   {4'b0, g4},   8'h00);
        check({tag, ".v8"},   {7'b0, v8},   8'h00);
        check({tag, ".idx8"}, {5'b0, idx8}, 8'h00);
        check({tag, ".g8"},   g8,           8'h00);
        check({tag, ".v5"},   {7'b0, v5},   8'h00);
        check({tag, ".idx5"}, {5'b0, idx5}, 8'h00);
        check({tag, ".g5"},   {3'b0, g5},   8'h00);
        rst = 1'b0;
    endtask

    vec_t       t4[6];
    logic [7:0] gg;
    logic [7:0] seen;
    logic [2:0] ex;

    initial begin
        rst  = 1'b1;
        req4 = '0; req8 = '0; req5 = '0;
        rdy4 = 1'b1; rdy8 = 1'b1; rdy5 = 1'b1;
        @(posedge clk);
        do_reset("por");

        // Fixed priority, N=4: highest set index wins; idle keeps idx.
        t4 = '{
            '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00},
            '{8'h01, 1'b1, 1'b1, 3'd0, 8'h01},
            '{8'h03, 1'b1, 1'b1, 3'd1, 8'h02},
            '{8'h06, 1'b1, 1'b1, 3'd2, 8'h04},
            '{8'h0A, 1'b1, 1'b1, 3'd3, 8'h08},
            '{8'h00, 1'b1, 1'b0, 3'd3, 8'h00}
        };
        for (int i = 0; i < 6; i++) begin
            step(4, t4[i].req, t4[i].rdy, t4[i].v, t4[i].idx, t4[i].grant,
                 $sformatf("fix4[%0d]", i), gg);
        end

        // Fixed priority stall: winner 3 frozen while req drops to 0001.
        step(4, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, "fix4_stall_ld", gg);
        step(4, 8'h01, 1'b0, 1'b1, 3'd3, 8'h08, "fix4_stall_hold", gg);
        step(4, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, "fix4_stall_rel", gg);

        // Round-robin N=8, all requesting: 7,6,...,0,7 and each once per 8.
        do_reset("rst_rr8");
        seen = '0;
        for (int i = 0; i < 9; i++) begin
            ex = 3'(7 - (i % 8));
            step(8, 8'hFF, 1'b1, 1'b1, ex, 8'h01 << ex, $sformatf("rr8_all[%0d]", i), gg);
            if (i < 8) seen = seen | gg;
        end
        check("rr8_fair", seen, 8'hFF);
        // Pointer now 6; a lone requester above it still wins at once.
        step(8, 8'h80, 1'b1, 1'b1, 3'd7, 8'h80, "rr8_single_hi", gg);

        // Round-robin N=8 with two requesters at the extremes: 7,0,7,0.
        do_reset("rst_81");
        for (int i = 0; i < 4; i++) begin
            ex = (i % 2 == 0) ? 3'd7 : 3'd0;
            step(8, 8'h81, 1'b1, 1'b1, ex, 8'h01 << ex, $sformatf("rr8_81[%0d]", i), gg);
        end

        // Stall: idx=5 held for 3 cycles while req moves to 0x02.
        do_reset("rst_stall");
        step(8, 8'h20, 1'b1, 1'b1, 3'd5, 8'h20, "stall_ld", gg);
        for (int i = 0; i < 3; i++) begin
            step(8, 8'h02, 1'b0, 1'b1, 3'd5, 8'h20, $sformatf("stall_hold[%0d]", i), gg);
        end
        step(8, 8'h02, 1'b1, 1'b1, 3'd1, 8'h02, "stall_rel", gg);

        // Non-power-of-two N=5 round-robin: 4,0,4,0,4.
        do_reset("rst_rr5");
        for (int i = 0; i < 5; i++) begin
            ex = (i % 2 == 0) ? 3'd4 : 3'd0;
            step(5, 8'h11, 1'b1, 1'b1, ex, 8'h01 << ex, $sformatf("rr5[%0d]", i), gg);
        end

        // Reset during a stall discards the held result and the pointer.
        do_reset("rst_mid");
        step(8, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, "mid_ld", gg);
        step(8, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, "mid_hold", gg);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("[%0t] mid_rst valid=%0b idx=%0d grant=%0h", $time, v8, idx8, g8);
        check("mid_rst.valid", {7'b0, v8},   8'h00);
        check("mid_rst.idx",   {5'b0, idx8}, 8'h00);
        check("mid_rst.grant", g8,           8'h00);
        rst = 1'b0;
        step(8, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h80, "mid_first", gg);
        step(8, 8'hFF, 1'b1, 1'b1, 3'd6, 8'h40, "mid_second", gg);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
